// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic-array datapath: data word and FIFO read-controller states.
package dsp_sys_arr_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_tile_reader_if.sv
// FIFO-head and array-edge stream signals of the tile reader, bundled as one bus.
interface fifo_tile_reader_if #(
    parameter int unsigned BW = 2
);
    import dsp_sys_arr_pkg::*;

    word_t [BW-1:0] fifo_dat;
    logic           fifo_empty;
    logic           fifo_pop;
    word_t [BW-1:0] out_dat;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (
        input  fifo_dat, fifo_empty, out_ready,
        output fifo_pop, out_dat, out_valid, out_last
    );

    modport slave (
        output fifo_dat, fifo_empty, out_ready,
        input  fifo_pop, out_dat, out_valid, out_last
    );

endinterface

// File: rtl/skew_line.sv
// Load-enabled delay line of words; depth 0 is a plain wire.
module skew_line
    import dsp_sys_arr_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clk,
    input  logic  nRST,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, nRST, en};
            assign q = d;
        end else begin : g_dly
            word_t [DEPTH-1:0] sr;

            // Shift only when the output stage loads so lanes stay beat-aligned.
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fifo_tile_reader.sv
// Pops a programmed number of FIFO entries and streams them to the array edge.
// Optional diagonal lane skew under FIFO_RD_SKEW_EN.
module fifo_tile_reader
    import dsp_sys_arr_pkg::*;
#(
    parameter int unsigned BW    = 2,
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    fifo_tile_reader_if.master   bus,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned FCNT_W     = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned FLUSH_LAST = (BW > 1) ? BW - 2 : 0;

    rd_state_t          state;
    logic [LEN_W-1:0]   rem;
    logic [FCNT_W-1:0]  fcnt;
    logic               slot;
    logic               pop;
    logic               flush_load;
    logic               load;
    logic               last_load;
    word_t [BW-1:0]     lane_q;

    assign slot = !bus.out_valid || bus.out_ready;
    assign pop  = (state == STREAM) && !bus.fifo_empty && (rem != '0) && slot;
    assign load = pop || flush_load;
    assign bus.fifo_pop = pop;

`ifdef FIFO_RD_SKEW_EN
    word_t [BW-1:0] lane_in;

    assign flush_load = (state == FLUSH) && slot;
    assign lane_in    = (state == FLUSH) ? '0 : bus.fifo_dat;
    assign last_load  = (BW > 1) ? (flush_load && (fcnt == FCNT_W'(FLUSH_LAST)))
                                 : (pop && (rem == LEN_W'(1)));

    // Lane b is delayed by b loads.
    for (genvar b = 0; b < int'(BW); b++) begin : g_lane
        skew_line #(.DEPTH(b)) u_skew (
            .clk  (clk),
            .nRST (nRST),
            .en   (load),
            .d    (lane_in[b]),
            .q    (lane_q[b])
        );
    end
`else
    assign flush_load = 1'b0;
    assign lane_q     = bus.fifo_dat;
    assign last_load  = pop && (rem == LEN_W'(1));
`endif

    // Control FSM plus the registered output stage.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            rem           <= '0;
            fcnt          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.out_dat   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (load) begin
                bus.out_dat   <= lane_q;
                bus.out_valid <= 1'b1;
                bus.out_last  <= last_load;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        rem   <= len;
                        busy  <= 1'b1;
                        state <= (len == '0) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
`ifdef FIFO_RD_SKEW_EN
                            fcnt  <= '0;
                            state <= (BW > 1) ? FLUSH : DRAIN;
`else
                            state <= DRAIN;
`endif
                        end
                    end
                end
                FLUSH: begin
                    if (flush_load) begin
                        if (fcnt == FCNT_W'(FLUSH_LAST)) begin
                            state <= DRAIN;
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.out_valid || (bus.out_ready && bus.out_last)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tile_reader.sv
// Directed bench for fifo_tile_reader with a FIFO model and a beat scoreboard.
// Expectations follow FIFO_RD_SKEW_EN when it is defined for the build.
module tb_fifo_tile_reader;
    import dsp_sys_arr_pkg::*;

    localparam int unsigned BW    = 2;
    localparam int unsigned LEN_W = 8;
`ifdef FIFO_RD_SKEW_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int EXTRA = SK * (int'(BW) - 1);

    typedef word_t [BW-1:0] vec_t;
    typedef struct packed {
        logic last;
        vec_t dat;
    } beat_t;

    logic             clk = 1'b0;
    logic             nRST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    vec_t  mem [64];
    int    wr = 0;
    int    rd = 0;
    vec_t  tile_buf [8];
    beat_t sb [$];

    fifo_tile_reader_if #(.BW(BW)) bus ();

    fifo_tile_reader #(.BW(BW), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .nRST  (nRST),
        .start (start),
        .len   (len),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (wr == rd);
    assign bus.fifo_dat   = (wr == rd) ? '0 : mem[rd];

    always @(posedge clk) begin
        if (bus.fifo_pop) rd <= rd + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beats accepted at the coming edge are checked against the scoreboard.
    always @(negedge clk) begin
        if (nRST && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_beat", 64'(bus.out_dat), 64'(0));
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat", 64'({bus.out_last, bus.out_dat}), 64'(e));
            end
        end
        if (bus.fifo_pop) chk("pop_when_empty", 64'(bus.fifo_empty), 64'(0));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input word_t a, input word_t b);
        vec_t v;
        v[0] = a;
        v[1] = b;
        mem[wr] = v;
        wr = wr + 1;
    endtask

    task automatic set_tile(input int i, input word_t a, input word_t b);
        tile_buf[i][0] = a;
        tile_buf[i][1] = b;
    endtask

    task automatic expect_tile(input int n);
        for (int k = 0; k < n + EXTRA; k++) begin
            beat_t e;
            e.dat = '0;
            for (int b = 0; b < int'(BW); b++) begin
                int idx;
                idx = k - b * SK;
                if (idx >= 0 && idx < n) e.dat[b] = tile_buf[idx][b];
            end
            e.last = (k == n + EXTRA - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_tile(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            step();
            cyc++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int rd0;
        vec_t hold;

        nRST          = 1'b0;
        start         = 1'b0;
        len           = '0;
        bus.out_ready = 1'b0;
        step(2);
        chk("rst_out_dat",   64'(bus.out_dat),   64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_last",  64'(bus.out_last),  64'(0));
        chk("rst_fifo_pop",  64'(bus.fifo_pop),  64'(0));
        chk("rst_busy",      64'(busy),          64'(0));
        chk("rst_done",      64'(done),          64'(0));
        nRST = 1'b1;
        step();

        // Basic tile of three entries at full rate.
        push(16'hA000, 16'hA001); set_tile(0, 16'hA000, 16'hA001);
        push(16'hB000, 16'hB001); set_tile(1, 16'hB000, 16'hB001);
        push(16'hC000, 16'hC001); set_tile(2, 16'hC000, 16'hC001);
        expect_tile(3);
        rd0 = rd;
        bus.out_ready = 1'b1;
        start_tile(3);
        chk("t1_pop_cycle1",   64'(bus.fifo_pop),  64'(1));
        chk("t1_valid_cycle1", 64'(bus.out_valid), 64'(0));
        step();
        chk("t1_valid_cycle2", 64'(bus.out_valid), 64'(1));
        wait_done(20, cyc);
        chk("t1_done_cycle", 64'(2 + cyc), 64'(3 + EXTRA + 2));
        start = 1'b1;
        len   = LEN_W'(1);
        step();
        start = 1'b0;
        chk("t1_done_pulse",    64'(done), 64'(0));
        chk("t1_start_ignored", 64'(busy), 64'(0));
        chk("t1_pops",          64'(rd - rd0), 64'(3));
        chk("t1_fifo_empty",    64'(bus.fifo_empty), 64'(1));
        chk("t1_sb_empty",      64'(sb.size()), 64'(0));
        step(2);

        // Empty FIFO stalls the stream until entries arrive.
        set_tile(0, 16'h1110, 16'h1111);
        set_tile(1, 16'h2220, 16'h2221);
        expect_tile(2);
        rd0 = rd;
        start_tile(2);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_no_pop", 64'(bus.fifo_pop), 64'(0));
            step();
        end
        push(16'h1110, 16'h1111);
        #1;
        chk("t2_pop_on_push1", 64'(bus.fifo_pop), 64'(1));
        step();
        chk("t2_valid_after_push1", 64'(bus.out_valid), 64'(1));
        step(2);
        chk("t2_stall2_no_pop", 64'(bus.fifo_pop), 64'(0));
        push(16'h2220, 16'h2221);
        #1;
        chk("t2_pop_on_push2", 64'(bus.fifo_pop), 64'(1));
        step();
        chk("t2_valid_after_push2", 64'(bus.out_valid), 64'(1));
        wait_done(20, cyc);
        chk("t2_pops",     64'(rd - rd0), 64'(2));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));
        step(2);

        // Backpressure holds the output stage and blocks pops.
        push(16'h5050, 16'h5151); set_tile(0, 16'h5050, 16'h5151);
        push(16'h6060, 16'h6161); set_tile(1, 16'h6060, 16'h6161);
        push(16'h7070, 16'h7171); set_tile(2, 16'h7070, 16'h7171);
        push(16'h8080, 16'h8181); set_tile(3, 16'h8080, 16'h8181);
        expect_tile(4);
        rd0 = rd;
        start_tile(4);
        step();
        bus.out_ready = 1'b0;
        #1;
        hold = sb[0].dat;
        chk("t3_first_beat", 64'(bus.out_dat), 64'(hold));
        chk("t3_hold_no_pop", 64'(bus.fifo_pop), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_dat",   64'(bus.out_dat),   64'(hold));
            chk("t3_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("t3_hold_pop",   64'(bus.fifo_pop),  64'(0));
        end
        bus.out_ready = 1'b1;
        wait_done(30, cyc);
        chk("t3_pops",     64'(rd - rd0), 64'(4));
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));
        step(2);

        // Zero-length tile: done only.
        rd0 = rd;
        start_tile(0);
        cyc = 0;
        while (!done && cyc < 5) begin
            chk("t4_no_valid", 64'(bus.out_valid), 64'(0));
            chk("t4_no_pop",   64'(bus.fifo_pop),  64'(0));
            step();
            cyc++;
        end
        chk("t4_done_seen", 64'(done), 64'(1));
        step();
        chk("t4_done_pulse", 64'(done), 64'(0));
        chk("t4_idle",       64'(busy), 64'(0));
        chk("t4_pops",       64'(rd - rd0), 64'(0));
        step(2);

        // Reset in the middle of a tile, then a fresh one-entry tile.
        push(16'h9090, 16'h9191); set_tile(0, 16'h9090, 16'h9191);
        push(16'hA0A0, 16'hA1A1); set_tile(1, 16'hA0A0, 16'hA1A1);
        push(16'hB0B0, 16'hB1B1); set_tile(2, 16'hB0B0, 16'hB1B1);
        push(16'hC0C0, 16'hC1C1); set_tile(3, 16'hC0C0, 16'hC1C1);
        expect_tile(4);
        start_tile(4);
        step(2);
        nRST = 1'b0;
        #1;
        chk("t5_rst_out_dat",   64'(bus.out_dat),   64'(0));
        chk("t5_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("t5_rst_out_last",  64'(bus.out_last),  64'(0));
        chk("t5_rst_busy",      64'(busy),          64'(0));
        chk("t5_rst_done",      64'(done),          64'(0));
        chk("t5_rst_pop",       64'(bus.fifo_pop),  64'(0));
        sb.delete();
        step();
        nRST = 1'b1;
        step();
        tile_buf[0] = mem[rd];
        expect_tile(1);
        rd0 = rd;
        start_tile(1);
        wait_done(20, cyc);
        chk("t5_pops",     64'(rd - rd0), 64'(1));
        chk("t5_sb_empty", 64'(sb.size()), 64'(0));
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_tile_reader.md
# fifo_tile_reader

Read-side controller for the circular FIFO. On `start` it pops a programmed number of BW-lane entries from the FIFO and streams them to a systolic-array edge over a valid/ready interface, then pulses `done`. It sits between a row FIFO and the array input and owns the FIFO `pop`. It can optionally apply diagonal lane skew so that lane b reaches the array b beats after lane 0.

## Interface
Parameters:
- `BW`, 2, number of lanes per FIFO entry; matches the FIFO's `BW`.
- `LEN_W`, 8, width of the tile-length field.

Ports:
- `clk`  in  1  clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `len`  in  LEN_W  number of FIFO entries to read; latched on accepted `start`.
- `fifo_dat`  in  word_t[BW-1:0]  FIFO head entry (combinational; zero when empty).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_pop`  out  1  combinational pop strobe to the FIFO.
- `out_dat`  out  word_t[BW-1:0]  registered output vector.
- `out_valid`  out  1  `out_dat` holds a beat.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `out_last`  out  1  current beat is the final beat of the tile.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse at tile completion.

## Operation
- States (`rd_state_t`): IDLE, STREAM, FLUSH, DRAIN.
- IDLE:
  - `start` latches `len` into `rem` and moves to STREAM.
  - `start` with `len==0` moves directly to DRAIN.
  - `start` in any other state is ignored.
- Load-slot free: `slot = !out_valid || out_ready`.
- STREAM:
  - `fifo_pop = !fifo_empty && rem!=0 && slot`.
  - A pop loads `fifo_dat` into the output stage and decrements `rem`.
  - An empty FIFO stalls the stream with no pop and no error.
  - When `rem` reaches 0, go to FLUSH if skew is enabled, otherwise DRAIN.
- FLUSH (skew only):
  - Performs BW-1 loads of an all-zero vector, each gated by `slot`.
  - Then go to DRAIN.
- DRAIN:
  - Wait until `out_valid` clears, or the final beat is accepted.
  - Then pulse `done` for one cycle and return to IDLE.
  - `start` in the `done` cycle is ignored.
- `fifo_pop` is never asserted outside STREAM and never while `fifo_empty`.
- Output register behaviour:
  - A load sets `out_valid`.
  - `out_ready` without a load clears `out_valid`.
  - `out_dat` holds its value while `out_valid && !out_ready`.
- `out_last` is high with `out_valid` on the final beat of the tile.
- Beat counts per tile:
  - Without skew: `len` beats.
  - With skew: `len+BW-1` beats.
  - `len==0`: no beats, `done` only.
- Reset values: `out_dat=0`, `out_valid=0`, `out_last=0`, `fifo_pop=0`, `busy=0`, `done=0`, state IDLE, `rem=0`, skew lines all zero.
- Reset mid-tile: all of the above is cleared immediately. Entries already popped are lost; the FIFO is not restored.

## Timing
- Pop in cycle N makes the beat visible on `out_dat`/`out_valid` in cycle N+1 (one-cycle latency).
- Full throughput is one beat per cycle while `out_ready=1` and the FIFO is non-empty.
- `start` at cycle 0 gives the first possible pop at cycle 1. The first beat is valid at cycle 2.
- `done` is asserted in the cycle after the final beat handshake completes.

## Configuration
- `FIFO_RD_SKEW_EN` defined:
  - Lane b passes through a b-deep delay line that shifts only on output loads.
  - FLUSH inserts BW-1 zero loads so every lane drains.
  - Lane 0 has no delay.
- `FIFO_RD_SKEW_EN` undefined:
  - Lanes pass straight to the output register.
  - FLUSH is unreachable.

## Structure
- `dsp_sys_arr_pkg` holds:
  - `word_t` and `WORD_W` (existing).
  - `rd_state_t` enum (new).
- Sub-module `skew_line`:
  - Parameterised depth, load-enable shift register of `word_t`.
  - Reset to zero.
  - Depth 0 is a pass-through.
  - Instantiated per lane under `FIFO_RD_SKEW_EN`.

## Test plan
- No skew, BW=2, FIFO preloaded {A0,A1},{B0,B1},{C0,C1}, `len=3`, `out_ready=1` → three pops on consecutive cycles; beats A,B,C at cycles 2–4; `out_last` on C; `done` at cycle 5; FIFO empty.
- Skew enabled, same stimulus → 4 beats:
  - lane0: A0, B0, C0, 0
  - lane1: 0, A1, B1, C1
  - `out_last` on beat 4; exactly 3 pops.
- FIFO empty stall, `len=2` → `fifo_pop` stays 0 until the first push; output resumes one cycle after each push; `done` after 2 beats.
- Backpressure: hold `out_ready=0` for 3 cycles with `out_valid=1` → `out_dat` stable, no pops; release → streaming continues, no beat lost or duplicated.
- `len=0` → no pop, no `out_valid`, `done` pulse 1 cycle after `start`.
- Assert `nRST` mid-tile after 1 of 4 beats → all outputs zero, IDLE; a new `start` with `len=1` completes normally.
